// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The master side raises requests; the slave side (the arbiter) returns the grant.
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       expired;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  expired
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output expired
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a bounded grant tenure and a one-hot select.
// Every release passes through one IDLE bubble cycle, where re-arbitration happens.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 32'd8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rr_arbiter_4_if.slave arb
);

    localparam logic [7:0] C_MAX_HOLD = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_last;
    logic [7:0] r_hold;
    logic [1:0] r_gnt_idx;
    logic       r_gnt_valid;
    logic [3:0] r_gnt;
    logic       r_expired;

    state_t     w_state_nxt;
    logic [1:0] w_last_nxt;
    logic [7:0] w_hold_nxt;
    logic [1:0] w_gnt_idx_nxt;
    logic       w_gnt_valid_nxt;
    logic [3:0] w_gnt_nxt;
    logic       w_expired_nxt;

    logic       w_any_req;
    logic [1:0] w_winner;
    logic       w_owner_req;
    logic       w_limit_hit;
    logic [7:0] w_hold_inc;

    // Scan from last+1 upward with wrap; the descending loop lets the nearest
    // candidate overwrite farther ones, leaving 'last' itself at lowest priority.
    function automatic logic [1:0] f_pick(input logic [3:0] req_v, input logic [1:0] last_v);
        logic [1:0] pick;
        logic [1:0] cand;
        pick = last_v;
        for (int k = 4; k >= 1; k--) begin
            cand = last_v + 2'(k);
            if (req_v[cand]) begin
                pick = cand;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] f_decode(input logic [1:0] idx);
        logic [3:0] onehot;
        case (idx)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

    // Arbitration inputs shared by both states.
    always_comb begin
        w_any_req   = (arb.req != 4'b0000);
        w_winner    = f_pick(arb.req, r_last);
        w_owner_req = arb.req[r_gnt_idx];
        w_limit_hit = (C_MAX_HOLD != 8'd0) && (r_hold == C_MAX_HOLD);
        w_hold_inc  = (r_hold == 8'hFF) ? 8'hFF : (r_hold + 8'd1);
    end

    // Next-state and next-output logic; the owner dropping its request takes
    // precedence over the hold limit, so a coincident drop is a normal release.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_hold_nxt      = r_hold;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_expired_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt     = ST_GRANT;
                    w_gnt_idx_nxt   = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = 8'd1;
                end else begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_valid_nxt = 1'b0;
                    w_hold_nxt      = 8'd0;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_valid_nxt = 1'b0;
                    w_last_nxt      = r_gnt_idx;
                    w_hold_nxt      = 8'd0;
                end else if (w_limit_hit) begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_valid_nxt = 1'b0;
                    w_last_nxt      = r_gnt_idx;
                    w_hold_nxt      = 8'd0;
                    w_expired_nxt   = 1'b1;
                end else begin
                    w_state_nxt     = ST_GRANT;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = w_hold_inc;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_gnt_valid_nxt = 1'b0;
                w_hold_nxt      = 8'd0;
            end
        endcase

        if (w_gnt_valid_nxt) begin
            w_gnt_nxt = f_decode(w_gnt_idx_nxt);
        end else begin
            w_gnt_nxt = 4'b0000;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_last      <= 2'b11;
            r_hold      <= 8'd0;
            r_gnt_idx   <= 2'b00;
            r_gnt_valid <= 1'b0;
            r_gnt       <= 4'b0000;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_hold      <= w_hold_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt       <= w_gnt_nxt;
            r_expired   <= w_expired_nxt;
        end
    end

    assign arb.gnt       = r_gnt;
    assign arb.gnt_idx   = r_gnt_idx;
    assign arb.gnt_valid = r_gnt_valid;
    assign arb.expired   = r_expired;

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one downstream resource (the decoded select bus) among 4 requesters.
- Picks a winner and holds the grant while the winner keeps requesting, up to a programmable limit.
- Drives a 2-bit grant index and its registered one-hot 2-to-4 decode, so downstream logic sees a one-hot select.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per tenure; legal range 0..255; 0 = unlimited hold.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request vector; bit i = requester i
- gnt  output  4  one-hot grant; decode of gnt_idx gated by gnt_valid; all-zero when no grant
- gnt_idx  output  2  index of current grantee; meaningful only when gnt_valid=1
- gnt_valid  output  1  a grant is active this cycle
- expired  output  1  one-cycle pulse: current tenure was force-ended by MAX_HOLD

Behaviour:
- All outputs are registered. clk and rst are the only clock and reset.
- Reset (synchronous, active-high):
  - gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, expired=0.
  - state=IDLE, last pointer=2'b11 (so requester 0 has top priority first), hold counter=0.
  - rst asserted mid-grant clears everything at the next edge; no expired pulse.
- States are IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE; outputs remain zero.
  - Otherwise the winner is the first set bit scanning from (last+1) mod 4 upward with wrap (order last+1, last+2, last+3, last).
  - On the sampling edge, load gnt_idx=winner and set gnt_valid=1, gnt=1<<winner, hold counter=1; go to GRANT.
  - Latency: request sampled at edge N gives a grant visible after edge N (1 cycle).
- GRANT, evaluated at each edge:
  - Normal release: req[gnt_idx]=0. Clear gnt/gnt_valid, set last=gnt_idx, go to IDLE, expired=0.
  - Forced release: req[gnt_idx]=1 and MAX_HOLD!=0 and hold counter==MAX_HOLD. Clear the grant, set last=gnt_idx, go to IDLE, set expired=1 for exactly one cycle.
  - Otherwise hold the grant and increment the hold counter (8 bits, saturating; it is not compared when MAX_HOLD=0).
  - Requests from other requesters never preempt an active grant.
- Bubble: every release yields exactly one cycle with gnt_valid=0 (IDLE) before the next grant. Re-arbitration happens in that IDLE cycle.
- Fairness: after any release, the released requester has lowest priority. With all 4 requesting continuously, grants rotate 0,1,2,3,0...
- Simultaneous events: if req[gnt_idx] drops on the same edge the limit is reached, it is a normal release (expired=0).
- A requester that re-raises req in the bubble cycle is eligible, but at lowest priority.
- Invariant: gnt is always one-hot or zero and equals the decode of gnt_idx whenever gnt_valid=1.
- expired is 0 in every cycle except the one following a forced release.
- Grant tenure length in cycles = number of edges at which the grant is held, between 1 and MAX_HOLD when MAX_HOLD!=0.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0000, gnt_valid=0, expired=0 throughout.
- After reset, req=4'b0110 held -> first grant is gnt=0010 (idx1) one cycle later. After MAX_HOLD=8 granted cycles: expired pulses, one bubble cycle, then gnt=0100 (idx2).
- req=4'b1111 held, MAX_HOLD=2 -> grant sequence idx 0,1,2,3,0. Each tenure is 2 cycles plus 1 bubble, and expired pulses once per tenure.
- Grant to idx0, drop req[0] after 3 cycles while req[3]=1 -> normal release, expired=0, bubble, then gnt=1000.
- req[1] dropped on exactly the 8th granted cycle -> release with expired=0.
- rst asserted while gnt=0100 -> after that edge all outputs are 0. With req=4'b1111 after rst deasserts, the next grant is idx0 (pointer reset to 3).
